music_player_core: RTL
======================

// Module: music_player_core
// PURPOSE
//  Parametrised successor to the fixed-tempo speaker chain: beat timer, beat sequencer with start/pause/stop/loop
//  control, and phase-continuous tone oscillator in one block. Drives song address to an external combinational
//  tone ROM and returns the tone in Hz. Produces the audio square wave plus amplifier control for the PMOD speaker.
// PARAMETERS
//  CLK_FREQ  100_000_000  system clock in Hz
//  BEAT_HZ   8            beats per second; BEAT_DIV = CLK_FREQ/BEAT_HZ clocks per beat (integer, >=2)
//  SONG_LEN  128          beats in song; last address = SONG_LEN-1
//  ADDR_W    8            beat_addr width; 2**ADDR_W >= SONG_LEN
//  TONE_W    32           tone input width (Hz)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-low reset (0 = reset)
//  start      in   1       1-cycle strobe: play from beat 0 (IDLE/DONE) or resume (PAUSE)
//  pause      in   1       1-cycle strobe: toggle PLAY<->PAUSE
//  stop       in   1       1-cycle strobe: abort to IDLE
//  loop_en    in   1       level: wrap to beat 0 after last beat instead of finishing
//  tone       in   TONE_W  Hz for current beat_addr from external ROM; 0 = rest
//  beat_addr  out  ADDR_W  current beat index
//  pwm        out  1       audio square wave
//  amp_gain   out  1       constant 1 (6 dB)
//  amp_en     out  1       1 in PLAY and PAUSE, else 0
//  playing    out  1       1 only in PLAY
//  done       out  1       1-cycle pulse when last beat ends with loop_en=0
// BEHAVIOUR
//  Reset: state=IDLE, beat_addr=0, beat counter=0, phase acc=0, pwm=0, amp_en=0, playing=0, done=0, amp_gain=1.
//  Strobe priority same cycle: stop > start > pause. Strobes irrelevant to the current state are ignored.
//  FSM:
//   IDLE : start -> PLAY with beat_addr=0, beat counter=0.
//   PLAY : stop -> IDLE (beat_addr=0); pause -> PAUSE; last-beat tick: loop_en=1 -> beat_addr=0 and stay PLAY,
//          else -> DONE with done=1 for that one cycle.
//   PAUSE: start or pause -> PLAY, resuming with held beat_addr, beat counter, phase acc; stop -> IDLE.
//   DONE : start -> PLAY from beat 0; stop -> IDLE. beat_addr holds SONG_LEN-1.
//  Beat timer: counts 0..BEAT_DIV-1 only in PLAY; beat tick on cycle count==BEAT_DIV-1, count wraps to 0.
//   Held in PAUSE; cleared in IDLE/DONE. beat_addr updates in the cycle after the tick edge (registered).
//   First beat lasts exactly BEAT_DIV clocks after the start strobe.
//  Tone oscillator: HALF = CLK_FREQ/2. tone registered (tone_q, 1-cycle latency). Each PLAY cycle, acc += inc, where
//   inc = min(tone_q, HALF). If acc+inc >= HALF: acc <- acc+inc-HALF and pwm toggles. Average pwm frequency = tone Hz.
//   acc is ACC_W = clog2(CLK_FREQ)+1 bits; no overflow by construction.
//   tone_q==0 (rest): pwm forced 0, acc held. Tone change mid-song: acc kept (phase continuous, no glitch reset).
//   PAUSE: pwm driven 0, acc held. IDLE/DONE: pwm=0, acc=0.
//  All outputs registered; no combinational path from inputs to outputs.
//  Reset asserted mid-song: immediate return to reset values; start strobe needed after release.
// STRUCTURE
//  Shared package: FSM state encoding (S_IDLE=0, S_PLAY=1, S_PAUSE=2, S_DONE=3) and a clog2 function.
//  One sub-module: tone_nco (clk, reset, en, clr, tone, pwm) holding acc/toggle logic; FSM + beat timer at top level.
// TESTING  (sim params: CLK_FREQ=1000, BEAT_HZ=10 -> BEAT_DIV=100, SONG_LEN=4, HALF=500)
//  1 start, loop_en=0, ROM tone=50 -> beat_addr 0,1,2,3 at 100-clock spacing; done=1 for one cycle 400 clks later;
//    state DONE, pwm=0; pwm period 20 clks (10 high/10 low) while playing.
//  2 loop_en=1 -> after beat 3 beat_addr returns to 0, playing stays 1, done never asserts over 1000 clks.
//  3 pause at clk 150, pause again at clk 300 -> beat_addr stays 1 and pwm=0 during pause;
//    beat 2 begins 50 clks after resume; pwm phase resumes without reset.
//  4 start+stop same cycle in IDLE -> stays IDLE; stop+pause in PLAY -> IDLE, beat_addr=0, amp_en=0.
//  5 tone 0 at beat 1 -> pwm low for that beat; tone 700 (>HALF) -> clamped, pwm toggles every cycle.
//  6 reset low mid-beat 2 -> all outputs at reset values asynchronously; after release, idle until start.

Source files
------------

// File: rtl/music_player_core_pkg.sv
// Shared definitions for the music player core.
// Holds the FSM state encoding and a constant-foldable clog2.
package music_player_core_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input longint v);
        int     r;
        longint x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/music_player_core_tone_nco.sv
// Phase-continuous square-wave oscillator: pwm averages tone Hz.
// Ports: clk, reset (async, active low), en (advance phase), clr (zero phase),
//        tone (Hz, 0 = rest), pwm (square wave out).
module tone_nco
    import music_player_core_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TONE_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [TONE_W-1:0] tone,
    output logic              pwm
);

    localparam int HALF  = CLK_FREQ / 2;
    localparam int ACC_W = clog2(CLK_FREQ) + 1;

    localparam logic [TONE_W-1:0] HALF_T = TONE_W'(HALF);
    localparam logic [ACC_W-1:0]  HALF_A = ACC_W'(HALF);

    logic [TONE_W-1:0] tone_q;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W-1:0]  sum;

    // Tones above Nyquist clamp to a toggle every cycle.
    always_comb begin
        inc = (tone_q > HALF_T) ? HALF_A : ACC_W'(tone_q);
        sum = acc + inc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tone_q <= '0;
            acc    <= '0;
            pwm    <= 1'b0;
        end else begin
            tone_q <= tone;
            if (clr) begin
                acc <= '0;
                pwm <= 1'b0;
            end else if (en && (tone_q != '0)) begin
                if (sum >= HALF_A) begin
                    acc <= sum - HALF_A;
                    pwm <= ~pwm;
                end else begin
                    acc <= sum;
                end
            end else begin
                // Rest or pause: silence, keep phase.
                pwm <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/music_player_core.sv
// Music player: beat timer, start/pause/stop/loop sequencer, tone NCO.
// Ports: clk, reset (async, active low), start/pause/stop strobes, loop_en,
//        tone (ROM Hz) -> beat_addr, pwm, amp_gain, amp_en, playing, done.
module music_player_core
    import music_player_core_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BEAT_HZ  = 8,
    parameter int SONG_LEN = 128,
    parameter int ADDR_W   = 8,
    parameter int TONE_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [TONE_W-1:0] tone,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              pwm,
    output logic              amp_gain,
    output logic              amp_en,
    output logic              playing,
    output logic              done
);

    localparam int BEAT_DIV = CLK_FREQ / BEAT_HZ;
    localparam int CNT_W    = clog2(BEAT_DIV);

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BEAT_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SONG_LEN - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  beat_cnt;
    logic              tick;
    logic              song_end;
    logic              done_d;
    logic              run_cnt;
    logic              keep_cnt;
    logic              restart;

    assign tick     = (state == S_PLAY) && (beat_cnt == CNT_MAX);
    assign song_end = tick && (beat_addr == LAST) && !loop_en;

    always_comb begin
        next_state = state;
        done_d     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !stop) next_state = S_PLAY;
            end
            S_PLAY: begin
                // End of song outranks a simultaneous pause.
                if (stop) begin
                    next_state = S_IDLE;
                end else if (song_end) begin
                    next_state = S_DONE;
                    done_d     = 1'b1;
                end else if (pause) begin
                    next_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) next_state = S_IDLE;
                else if (start || pause) next_state = S_PLAY;
            end
            S_DONE: begin
                if (stop) next_state = S_IDLE;
                else if (start) next_state = S_PLAY;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign run_cnt  = (state == S_PLAY) &&
                      ((next_state == S_PLAY) || (next_state == S_PAUSE));
    assign keep_cnt = (state == S_PAUSE) && (next_state != S_IDLE);
    assign restart  = ((state == S_IDLE) || (state == S_DONE)) &&
                      (next_state == S_PLAY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            beat_addr <= '0;
            done      <= 1'b0;
            playing   <= 1'b0;
            amp_en    <= 1'b0;
        end else begin
            state   <= next_state;
            done    <= done_d;
            playing <= (next_state == S_PLAY);
            amp_en  <= (next_state == S_PLAY) || (next_state == S_PAUSE);

            if (run_cnt) begin
                beat_cnt <= tick ? '0 : beat_cnt + CNT_W'(1);
            end else if (!keep_cnt) begin
                beat_cnt <= '0;
            end

            if ((next_state == S_IDLE) || restart) begin
                beat_addr <= '0;
            end else if (tick && !song_end) begin
                beat_addr <= (beat_addr == LAST) ? '0 : beat_addr + ADDR_W'(1);
            end
        end
    end

    assign amp_gain = 1'b1;

    tone_nco #(
        .CLK_FREQ (CLK_FREQ),
        .TONE_W   (TONE_W)
    ) u_nco (
        .clk   (clk),
        .reset (reset),
        .en    (state == S_PLAY),
        .clr   ((state == S_IDLE) || (state == S_DONE)),
        .tone  (tone),
        .pwm   (pwm)
    );

endmodule
